// File: rtl/wb_write_arbiter_if.sv
// Regfile write-arbiter bus.
//
// Bundles every signal that passes between the write arbiter and its
// neighbours: the in-order writeback stage, the MUL/DIV result handshake,
// the stall request back to the pipeline and the regfile write port.
//
// Modports:
//   master - the arbiter's view: it consumes pipeline/MUL-DIV results and
//            drives div_ready, pipe_stall, fifo_level and the write port.
//   slave  - the surrounding pipeline/regfile's view (the reverse).
//
// Parameter DEPTH must match the DEPTH of the arbiter attached to it; it only
// sizes fifo_level.
interface wb_write_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             pipe_wr_en;
    logic [4:0]       pipe_dest;
    logic [31:0]      pipe_data;
    logic             div_valid;
    logic             div_ready;
    logic [4:0]       div_dest;
    logic [31:0]      div_data;
    logic             pipe_stall;
    logic [LVL_W-1:0] fifo_level;
    logic             wr_en;
    logic [4:0]       dest_addr;
    logic [31:0]      wr_data;

    modport master (
        input  pipe_wr_en, pipe_dest, pipe_data,
        input  div_valid, div_dest, div_data,
        output div_ready, pipe_stall, fifo_level,
        output wr_en, dest_addr, wr_data
    );

    modport slave (
        output pipe_wr_en, pipe_dest, pipe_data,
        output div_valid, div_dest, div_data,
        input  div_ready, pipe_stall, fifo_level,
        input  wr_en, dest_addr, wr_data
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Regfile write-port arbiter for the RV32IMC pipeline.
//
// Merges the fixed-timing writeback stage with late MUL/DIV results. The
// writeback stage always wins a slot; MUL/DIV results wait in a small FIFO and
// are drained into slots the pipeline leaves idle. If the FIFO sits non-empty
// for STARVE_LIMIT consecutive pipeline writes, pipe_stall asks the pipeline
// for a bubble so the head can drain.
//
// Ports:
//   clk   - rising-edge clock
//   nrst  - synchronous active-low reset, clears all state including the FIFO
//   bus   - wb_write_arbiter_if.master: pipeline result (pipe_*), MUL/DIV
//           handshake (div_*), pipe_stall, fifo_level and the registered
//           regfile write port (wr_en, dest_addr, wr_data)
//
// Parameters:
//   DEPTH        - FIFO entries, power of two, 2..16
//   STARVE_LIMIT - starvation threshold in cycles, 1..255
//
// Build option:
//   WB_X0_FILTER_EN - when defined, a selected result aimed at x0 is consumed
//                     but produces wr_en=0 for that slot.
module wb_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               nrst,
    wb_write_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] LIMIT_L = CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       dest_q, dest_d;
    logic [31:0]      data_q, data_d;

    logic             fifo_empty;
    logic             div_ready;
    logic             enq;
    logic             pop;
    entry_t           head;

    // div_ready looks only at the registered level, so a pop in the same cycle
    // never opens room for an enqueue; this keeps div_ready free of any path
    // from pipe_wr_en.
    always_comb begin
        fifo_empty = (level_q == '0);
        div_ready  = (level_q < DEPTH_L);
        enq        = bus.div_valid & div_ready;
        pop        = ~bus.pipe_wr_en & ~fifo_empty;
        head       = mem_q[rd_ptr_q];
    end

    // FIFO storage and pointers. Pointers are PTR_W bits wide, so with a
    // power-of-two DEPTH they wrap on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (enq) begin
            mem_d[wr_ptr_q] = '{dest: bus.div_dest, data: bus.div_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (enq && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!enq && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Slot selection: pipeline first, then FIFO head, else an idle slot where
    // address and data hold their last values.
    always_comb begin
        wr_en_d = 1'b0;
        dest_d  = dest_q;
        data_d  = data_q;
        if (bus.pipe_wr_en) begin
            dest_d = bus.pipe_dest;
            data_d = bus.pipe_data;
`ifdef WB_X0_FILTER_EN
            wr_en_d = (bus.pipe_dest != 5'd0);
`else
            wr_en_d = 1'b1;
`endif
        end else if (!fifo_empty) begin
            dest_d = head.dest;
            data_d = head.data;
`ifdef WB_X0_FILTER_EN
            wr_en_d = (head.dest != 5'd0);
`else
            wr_en_d = 1'b1;
`endif
        end
    end

    // Starvation tracking. The count only grows while the pipeline holds the
    // slot over a waiting FIFO, so it can only return to zero through a pop.
    // The stall flop is loaded from the next count, which makes pipe_stall
    // rise in the same cycle the count first shows STARVE_LIMIT and hold until
    // a pop clears the count, even if the pipeline ignores the stall.
    always_comb begin
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (bus.pipe_wr_en && (starve_q != LIMIT_L)) begin
            starve_d = starve_q + CNT_W'(1);
        end else begin
            starve_d = starve_q;
        end
        stall_d = (starve_d == LIMIT_L);
    end

    // State registers with synchronous reset; reset drops any buffered results.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            wr_en_q  <= wr_en_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

    assign bus.div_ready  = div_ready;
    assign bus.pipe_stall = stall_q;
    assign bus.fifo_level = level_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.dest_addr  = dest_q;
    assign bus.wr_data    = data_q;
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Drives the regfile write port (wr_en, dest_addr, wr_data) for the RV32IMC pipeline; it is the writer end of the regfile write interface.
- Merges two result sources:
  - the in-order writeback stage, which has fixed timing and cannot be stalled;
  - the multi-cycle MUL/DIV unit, which returns results late through a valid/ready handshake.
- Late results are buffered in a small FIFO and drained into idle write slots. A starvation counter forces a pipeline bubble when the FIFO is not draining.

Parameters:
- DEPTH, 4, number of MUL/DIV result FIFO entries (power of 2, 2..16)
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may go without draining before pipe_stall is raised (1..255)

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  synchronous active-low reset
- pipe_wr_en  input  1  writeback stage has a result this cycle
- pipe_dest  input  5  writeback destination register
- pipe_data  input  32  writeback data
- div_valid  input  1  MUL/DIV result available
- div_ready  output  1  FIFO can accept a result this cycle
- div_dest  input  5  MUL/DIV destination register
- div_data  input  32  MUL/DIV result
- pipe_stall  output  1  request one-cycle bubble in the writeback stage
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
- wr_en  output  1  regfile write enable
- dest_addr  output  5  regfile write address
- wr_data  output  32  regfile write data

Behaviour:
- Clock, reset and registers:
  - Single clock. Reset is synchronous and active-low: nrst sampled low at a rising edge clears all state.
  - Reset values: wr_en=0, dest_addr=0, wr_data=0, pipe_stall=0, fifo_level=0, FIFO empty, starve count=0.
  - Reset asserted mid-operation discards any buffered results.
- Outputs:
  - wr_en, dest_addr and wr_data are registered. A source selected in cycle N appears on the write port in cycle N+1. The regfile commits at the edge ending cycle N+1.
  - div_ready = (fifo_level < DEPTH). It is combinational from registered count only; dequeue in the same cycle does not make room.
- Enqueue:
  - A result is enqueued at the edge where div_valid & div_ready.
  - The head becomes eligible for drain in the next cycle; there is no same-cycle pass-through.
- Selection each cycle (priority order):
  - pipe_wr_en=1: the pipeline source is selected. The FIFO holds.
  - else FIFO non-empty: the head is selected and popped at the edge.
  - else: nothing is selected; wr_en=0 next cycle and dest_addr/wr_data hold their previous values.
- Simultaneous enqueue and pop: both take effect; fifo_level is unchanged.
- Pointers are DEPTH-modulo and wrap naturally; order is strict FIFO.
- Starvation counter:
  - Increments on each cycle where the FIFO is non-empty and pipe_wr_en=1.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - pipe_stall is registered: it is 1 in the cycle after the count reaches STARVE_LIMIT, and stays 1 until a pop occurs.
- Pipeline contract: while pipe_stall=1 the pipeline presents pipe_wr_en=0. If it violates this, the pipeline still wins and pipe_stall remains asserted.
- Same-register ordering: the pipeline never writes a register with an outstanding MUL/DIV result (enforced by hazard logic elsewhere). This block does not reorder by register.
- Width rules: dest fields are 5 bits and data is 32 bits, passed unmodified.

Optional Feature:
- WB_X0_FILTER_EN
  - Defined: a selected source with destination 0 is consumed normally (popped or accepted), but wr_en stays 0 for that slot. The x0-destined FIFO entry frees its slot without a write.
  - Undefined: x0 writes are driven to the port with wr_en=1; the regfile discards them.

Test Plan:
- Reset check: hold nrst=0 for 10 cycles with random inputs, then release -> wr_en=0, pipe_stall=0, fifo_level=0, div_ready=1.
- Pipeline-only write: pipe_wr_en=1, pipe_dest=1, pipe_data=0xADE1B055 for one cycle -> next cycle wr_en=1, dest_addr=1, wr_data=0xADE1B055; regfile x1=0xADE1B055 after that edge.
- Idle-slot drain: div result 0x0000000A to x10 accepted in cycle N with the pipeline idle -> fifo_level=1 in N+1; wr_en=1, dest_addr=10, wr_data=0xA in N+2; fifo_level=0.
- Full FIFO: pipe_wr_en held 1 and 5 div results offered (DEPTH=4) -> 4 accepted, div_ready=0 on the 5th, fifo_level=4; after release, entries drain in order, one per cycle.
- Starvation: pipe_wr_en held 1 with 1 FIFO entry, STARVE_LIMIT=8 -> pipe_stall=1 in the 9th cycle. Bench drops pipe_wr_en -> head written next cycle, pipe_stall back to 0.
- x0 filter: with WB_X0_FILTER_EN, pipe_dest=0 data 0xFFFFFFFF -> wr_en stays 0. Without the macro -> wr_en=1, dest_addr=0, and regfile x0 still reads 0.
